// File: rtl/clmul_pkg.sv
// Shared types and elaboration helpers for the digit-serial carry-less multiplier.
package clmul_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Never returns less than 1, so the result can always size a counter.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic logic [126:0] clmul_ref(input logic [63:0] a, input logic [63:0] b);
    logic [126:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (b[i]) r = r ^ ({63'b0, a} << i);
    return r;
  endfunction

endpackage

// File: rtl/clmul_digit.sv
// Combinational WIDTH x DIGIT carry-less multiplier: one digit row per call.
module clmul_digit #(
  parameter int WIDTH = 26,
  parameter int DIGIT = 4
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       d,
  output logic [WIDTH+DIGIT-2:0] p
);

  localparam int PW = WIDTH + DIGIT - 1;

  always_comb begin
    p = '0;
    for (int j = 0; j < DIGIT; j++)
      if (d[j]) p = p ^ (PW'(a) << j);
  end

endmodule

// File: rtl/clmul_digit_serial.sv
// Sequential GF(2)[x] multiplier consuming DIGIT bits of b per cycle, LSB digit first,
// with optional XOR-accumulation into the previously delivered result.
module clmul_digit_serial
  import clmul_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-2:0] y
);

  localparam int NDIG  = ceil_div(WIDTH, DIGIT);
  localparam int CNT_W = clog2(NDIG);
  localparam int YW    = 2 * WIDTH - 1;
  localparam int PW    = WIDTH + DIGIT - 1;
  localparam int BW    = NDIG * DIGIT;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_p0;
  logic [BW-1:0]    b_p0;
  logic [YW-1:0]    acc;
  logic [PW-1:0]    partial;
  logic [YW-1:0]    acc_nxt;

  // b_p0 shifts right each cycle, so the live digit is always its low DIGIT bits;
  // the zero padding above WIDTH feeds the short final digit.
  clmul_digit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_digit (
    .a (a_p0),
    .d (b_p0[DIGIT-1:0]),
    .p (partial)
  );

  // Shifting in YW width drops only bits that are zero by construction.
  always_comb acc_nxt = acc ^ (YW'(partial) << (cnt * DIGIT));

  // y doubles as the previous-result register used by accumulate mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      y         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_p0     <= a;
            b_p0     <= BW'(b);
            cnt      <= '0;
            acc      <= acc_en ? y : '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_nxt;
          b_p0 <= b_p0 >> DIGIT;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            y         <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clmul_digit_serial.sv
// Bench for clmul_digit_serial: directed vector table, backpressure and reset
// sequences, and random operands on three parameter sets against a bitwise model.
module tb_clmul_digit_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] a, b;
  logic        acc_en;
  logic        iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2, or0, or1, or2;
  logic [50:0] y0, y1;
  logic [24:0] y2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  clmul_digit_serial #(.WIDTH(26), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .acc_en(acc_en), .out_valid(ov0), .out_ready(or0), .y(y0));

  clmul_digit_serial #(.WIDTH(26), .DIGIT(26)) u_d26 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .acc_en(acc_en), .out_valid(ov1), .out_ready(or1), .y(y1));

  clmul_digit_serial #(.WIDTH(13), .DIGIT(5)) u_d13 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a[12:0]), .b(b[12:0]),
    .acc_en(acc_en), .out_valid(ov2), .out_ready(or2), .y(y2));

  typedef struct {
    logic [25:0] a;
    logic [25:0] b;
    logic        acc;
    logic [50:0] y;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Product as the XOR of a shifted by every set bit of b, over w-bit operands.
  function automatic logic [50:0] ref_mul(input logic [25:0] x, input logic [25:0] z, input int w);
    logic [50:0] r;
    logic [25:0] m;
    m = (26'd1 << w) - 26'd1;
    r = '0;
    for (int i = 0; i < w; i++)
      if (z[i]) r = r ^ (51'(x & m) << i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic op_main(input logic [25:0] xa, input logic [25:0] xb, input logic xacc,
                         output logic [50:0] yo, output int lat);
    int n;
    n = 0;
    while (!ir0 && n < 50) begin tick(); n++; end
    if (!ir0) check("main_ready_timeout", 64'd0, 64'd1);
    a = xa; b = xb; acc_en = xacc; iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    lat = 0;
    while (!ov0 && lat < 50) begin tick(); lat++; end
    if (!ov0) check("main_done_timeout", 64'd0, 64'd1);
    yo = y0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [50:0] yo, yh, e0, e1, p0, p1;
    logic [24:0] e2, p2, g2;
    logic [50:0] g0, g1;
    logic [25:0] ra, rb;
    logic        rac, s0, s1, s2, stable, early;
    int          lat, n;

    vt[0] = '{26'h1,       26'h1,       1'b0, 51'h1};
    vt[1] = '{26'h3,       26'h3,       1'b0, 51'h5};
    vt[2] = '{26'h3FFFFFF, 26'h2000000, 1'b0, 51'h3FFFFFF << 25};
    vt[3] = '{26'h3FFFFFF, 26'h3FFFFFF, 1'b0, 51'h5555555555555};
    vt[4] = '{26'h3,       26'h3,       1'b0, 51'h5};
    vt[5] = '{26'h3,       26'h3,       1'b1, 51'h0};
    vt[6] = '{26'h2,       26'h1,       1'b1, 51'h2};

    rst_n = 1'b0; a = '0; b = '0; acc_en = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    do_reset();
    check("rst_in_ready", 64'(ir0), 64'd1);
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_y", 64'(y0), 64'd0);
    check("rst_ready_others", 64'({ir1, ir2}), 64'd3);

    for (int i = 0; i < 7; i++) begin
      op_main(vt[i].a, vt[i].b, vt[i].acc, yo, lat);
      check($sformatf("vec%0d_y", i), 64'(yo), 64'(vt[i].y));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd7);
      tick();
      check($sformatf("vec%0d_valid_drop", i), 64'(ov0), 64'd0);
      check($sformatf("vec%0d_ready_back", i), 64'(ir0), 64'd1);
    end

    // Backpressure: result held in DONE, input pulses ignored.
    or0 = 1'b0;
    op_main(26'h5, 26'h7, 1'b0, yh, lat);
    check("bp_y", 64'(yh), 64'h1B);
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      iv0 = k[0];
      a = 26'($urandom);
      b = 26'($urandom);
      tick();
      if (!(ov0 && !ir0 && y0 == yh)) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    a = 26'h3; b = 26'h3; acc_en = 1'b0; iv0 = 1'b1; or0 = 1'b1;
    tick();
    check("bp_release_valid", 64'(ov0), 64'd0);
    check("bp_release_ready", 64'(ir0), 64'd1);
    tick();
    check("bp_accept_from_idle", 64'(ir0), 64'd0);
    iv0 = 1'b0;
    lat = 0;
    while (!ov0 && lat < 50) begin tick(); lat++; end
    check("bp_next_y", 64'(y0), 64'h5);
    check("bp_next_latency", 64'(lat), 64'd7);
    tick();

    // Reset three cycles into BUSY aborts the operation.
    n = 0;
    while (!ir0 && n < 50) begin tick(); n++; end
    a = 26'h3FFFFFF; b = 26'h3FFFFFF; acc_en = 1'b0; iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 64'(ir0), 64'd1);
    check("midrst_out_valid", 64'(ov0), 64'd0);
    check("midrst_y", 64'(y0), 64'd0);
    early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ov0) early = 1'b1;
    end
    check("midrst_no_output", 64'(early), 64'd0);
    op_main(26'h2, 26'h3, 1'b1, yo, lat);
    check("midrst_acc_zero", 64'(yo), 64'h6);
    tick();

    // Random operands on all three parameter sets concurrently.
    do_reset();
    p0 = '0; p1 = '0; p2 = '0;
    for (int t = 0; t < 4000; t++) begin
      ra = 26'($urandom);
      rb = 26'($urandom);
      if (t % 64 == 0) ra = 26'h3FFFFFF;
      if (t % 64 == 1) rb = 26'h3FFFFFF;
      rac = 1'($urandom_range(0, 1));
      n = 0;
      while (!(ir0 && ir1 && ir2) && n < 50) begin tick(); n++; end
      if (!(ir0 && ir1 && ir2)) check("rnd_ready_timeout", 64'd0, 64'd1);
      a = ra; b = rb; acc_en = rac;
      iv0 = 1'b1; iv1 = 1'b1; iv2 = 1'b1;
      tick();
      iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
      s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
      g0 = '0; g1 = '0; g2 = '0;
      n = 0;
      while (!(s0 && s1 && s2) && n < 30) begin
        tick();
        n++;
        if (ov0 && !s0) begin s0 = 1'b1; g0 = y0; end
        if (ov1 && !s1) begin s1 = 1'b1; g1 = y1; end
        if (ov2 && !s2) begin s2 = 1'b1; g2 = y2; end
      end
      e0 = ref_mul(ra, rb, 26) ^ (rac ? p0 : 51'd0);
      e1 = ref_mul(ra, rb, 26) ^ (rac ? p1 : 51'd0);
      e2 = 25'(ref_mul(ra, rb, 13)) ^ (rac ? p2 : 25'd0);
      check("rnd_done_all", 64'({s0, s1, s2}), 64'd7);
      check("rnd_w26_d4", 64'(g0), 64'(e0));
      check("rnd_w26_d26", 64'(g1), 64'(e1));
      check("rnd_w13_d5", 64'(g2), 64'(e2));
      p0 = e0; p1 = e1; p2 = e2;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
